// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver: synchronises raw pins, shifts in MSB-first frames,
// and turns valid write frames into a one-cycle address/data strobe.
module spi_frame_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_i,
  input  logic       copi_i,
  input  logic       ncs_i,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err,
  output logic       busy
);
  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_OVR  = CW'(FRAME_BITS + 1);
  localparam logic [6:0]    ADDR_MAX = 7'(MAX_ADDR);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sclk_sync, copi_sync, ncs_sync;
  logic                    sclk_d, ncs_d;
  logic                    sclk_rise, ncs_rise, ncs_fall;
  logic [FRAME_BITS-1:0]   shreg;
  logic [CW-1:0]           cnt;
  logic                    sclk_s, copi_s, ncs_s;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign copi_s = copi_sync[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync[SYNC_STAGES-1];

  // Edge flags are registered; copi_s is still stable on the following cycle
  // because each SCLK phase lasts at least two clk cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b1;
      sclk_rise <= 1'b0;
      ncs_rise  <= 1'b0;
      ncs_fall  <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi_i};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs_i};
      sclk_d    <= sclk_s;
      ncs_d     <= ncs_s;
      sclk_rise <= sclk_s & ~sclk_d;
      ncs_rise  <= ncs_s & ~ncs_d;
      ncs_fall  <= ~ncs_s & ncs_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: if (ncs_fall) begin
          shreg <= '0;
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          // ncs rising wins over a coincident SCLK edge
          if (ncs_rise) begin
            state <= IDLE;
            if (cnt != CNT_FULL)
              frame_err <= 1'b1;
            else if (shreg[FRAME_BITS-1] && shreg[FRAME_BITS-2 -: 7] <= ADDR_MAX) begin
              wr_valid <= 1'b1;
              wr_addr  <= shreg[FRAME_BITS-2 -: 7];
              wr_data  <= shreg[7:0];
            end
          end else if (sclk_rise) begin
            shreg <= {shreg[FRAME_BITS-2:0], copi_s};
            if (cnt != CNT_OVR) cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == SHIFT);
endmodule

// File: tb/tb_spi_frame_rx.sv
// Bench for spi_frame_rx: directed scenarios plus random frames checked
// against a frame-level reference model of accept/drop/error behaviour.
module tb_spi_frame_rx;
  localparam int SYNC_STAGES = 2;
  localparam int MAX_ADDR    = 4;
  localparam int LAT         = SYNC_STAGES + 2;

  logic       clk = 0, rst = 1, sclk_i = 0, copi_i = 0, ncs_i = 1;
  logic       wr_valid, frame_err, busy;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  int checks = 0, errors = 0;
  logic [6:0] exp_addr = 0;
  logic [7:0] exp_data = 0;

  spi_frame_rx #(.SYNC_STAGES(SYNC_STAGES), .FRAME_BITS(16), .MAX_ADDR(MAX_ADDR)) dut (
    .clk(clk), .rst(rst), .sclk_i(sclk_i), .copi_i(copi_i), .ncs_i(ncs_i),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: 0 = drop, 1 = write, 2 = error
  function automatic int classify(input logic [31:0] v, input int n);
    if (n != 16) return 2;
    if (v[15] == 1'b0) return 0;
    if (int'(v[14:8]) > MAX_ADDR) return 0;
    return 1;
  endfunction

  task automatic drive_bits(input logic [31:0] v, input int n, input int half);
    for (int i = n - 1; i >= 0; i--) begin
      copi_i = v[i];
      wait_cyc(half);
      sclk_i = 1;
      wait_cyc(half);
      sclk_i = 0;
    end
  endtask

  task automatic watch(output int nv, output int ne, output int lat, output int both);
    nv = 0; ne = 0; lat = -1; both = 0;
    for (int c = 1; c <= 12; c++) begin
      wait_cyc(1);
      if (wr_valid) begin nv++; if (lat < 0) lat = c; end
      if (frame_err) ne++;
      if (wr_valid && frame_err) both++;
    end
  endtask

  task automatic frame(input logic [31:0] v, input int n, input int half,
                       output int nv, output int ne, output int lat, output int both,
                       output logic bsy);
    ncs_i = 0;
    wait_cyc(4);
    drive_bits(v, n, half);
    wait_cyc(half);
    bsy = busy;
    ncs_i = 1;
    watch(nv, ne, lat, both);
  endtask

  task automatic apply_model(input logic [31:0] v, input int n);
    if (classify(v, n) == 1) begin
      exp_addr = v[14:8];
      exp_data = v[7:0];
    end
  endtask

  task automatic test_reset;
    rst = 1; ncs_i = 1; sclk_i = 0; copi_i = 0;
    wait_cyc(3);
    rst = 0;
    wait_cyc(1);
    exp_addr = 0; exp_data = 0;
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got %b want 0", wr_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (wr_addr !== 7'h00) begin errors++; $display("FAIL reset_wr_addr got %h want 00", wr_addr); end
    checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got %h want 00", wr_data); end
    wait_cyc(4);
  endtask

  task automatic test_write;
    int nv, ne, lat, both; logic bsy;
    frame(32'h84AA, 16, 4, nv, ne, lat, both, bsy);
    apply_model(32'h84AA, 16);
    checks++; if (nv !== 1) begin errors++; $display("FAIL write_strobes got %0d want 1", nv); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL write_latency got %0d want %0d", lat, LAT); end
    checks++; if (ne !== 0) begin errors++; $display("FAIL write_err got %0d want 0", ne); end
    checks++; if (wr_addr !== 7'h04 || wr_data !== 8'hAA) begin errors++; $display("FAIL write_data got %h/%h want 04/aa", wr_addr, wr_data); end
    checks++; if (bsy !== 1'b1) begin errors++; $display("FAIL write_busy got %b want 1", bsy); end
  endtask

  task automatic test_back_to_back;
    int nv, ne, lat, both; logic bsy;
    frame(32'h80F0, 16, 3, nv, ne, lat, both, bsy);
    apply_model(32'h80F0, 16);
    checks++; if (nv !== 1 || ne !== 0) begin errors++; $display("FAIL b2b_first got v%0d e%0d want v1 e0", nv, ne); end
    checks++; if (wr_addr !== 7'h00 || wr_data !== 8'hF0) begin errors++; $display("FAIL b2b_first_data got %h/%h want 00/f0", wr_addr, wr_data); end
    frame(32'h0155, 16, 2, nv, ne, lat, both, bsy);
    apply_model(32'h0155, 16);
    checks++; if (nv !== 0 || ne !== 0) begin errors++; $display("FAIL b2b_read got v%0d e%0d want v0 e0", nv, ne); end
    checks++; if (wr_addr !== exp_addr || wr_data !== exp_data) begin errors++; $display("FAIL b2b_read_hold got %h/%h want %h/%h", wr_addr, wr_data, exp_addr, exp_data); end
  endtask

  task automatic test_addr_range;
    int nv, ne, lat, both; logic bsy;
    frame(32'h8512, 16, 3, nv, ne, lat, both, bsy);
    apply_model(32'h8512, 16);
    checks++; if (nv !== 0 || ne !== 0) begin errors++; $display("FAIL addr_range got v%0d e%0d want v0 e0", nv, ne); end
    checks++; if (wr_addr !== 7'h00 || wr_data !== 8'hF0) begin errors++; $display("FAIL addr_range_hold got %h/%h want 00/f0", wr_addr, wr_data); end
  endtask

  task automatic test_bad_length;
    int nv, ne, lat, both; logic bsy;
    frame(32'h4321, 15, 2, nv, ne, lat, both, bsy);
    checks++; if (ne !== 1 || nv !== 0) begin errors++; $display("FAIL short_frame got v%0d e%0d want v0 e1", nv, ne); end
    checks++; if (bsy !== 1'b1) begin errors++; $display("FAIL short_busy got %b want 1", bsy); end
    frame(32'h1_8123, 17, 2, nv, ne, lat, both, bsy);
    checks++; if (ne !== 1 || nv !== 0) begin errors++; $display("FAIL long_frame got v%0d e%0d want v0 e1", nv, ne); end
    checks++; if (bsy !== 1'b1) begin errors++; $display("FAIL long_busy got %b want 1", bsy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    checks++; if (wr_addr !== exp_addr || wr_data !== exp_data) begin errors++; $display("FAIL err_hold got %h/%h want %h/%h", wr_addr, wr_data, exp_addr, exp_data); end
  endtask

  task automatic test_abort;
    int nv, ne, lat, both; logic bsy;
    ncs_i = 0;
    wait_cyc(4);
    drive_bits(32'h83, 8, 3);
    rst = 1; ncs_i = 1; sclk_i = 0;
    wait_cyc(1);
    rst = 0;
    exp_addr = 0; exp_data = 0;
    watch(nv, ne, lat, both);
    checks++; if (nv !== 0 || ne !== 0) begin errors++; $display("FAIL abort_out got v%0d e%0d want v0 e0", nv, ne); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    frame(32'h8301, 16, 3, nv, ne, lat, both, bsy);
    apply_model(32'h8301, 16);
    checks++; if (nv !== 1 || wr_addr !== 7'h03 || wr_data !== 8'h01) begin errors++; $display("FAIL after_abort got v%0d %h/%h want v1 03/01", nv, wr_addr, wr_data); end
  endtask

  task automatic test_ncs_low_reset;
    int nv, ne, lat, both; logic bsy;
    ncs_i = 0; rst = 1;
    wait_cyc(2);
    rst = 0;
    exp_addr = 0; exp_data = 0;
    frame(32'h8277, 16, 2, nv, ne, lat, both, bsy);
    apply_model(32'h8277, 16);
    checks++; if (nv !== 1 || ne !== 0) begin errors++; $display("FAIL low_reset got v%0d e%0d want v1 e0", nv, ne); end
    checks++; if (wr_addr !== 7'h02 || wr_data !== 8'h77) begin errors++; $display("FAIL low_reset_data got %h/%h want 02/77", wr_addr, wr_data); end
  endtask

  task automatic test_random;
    int nv, ne, lat, both, n, half, kind; logic bsy; logic [31:0] v;
    for (int k = 0; k < 24; k++) begin
      v = $urandom;
      case ($urandom_range(0, 5))
        0: n = 15;
        1: n = 17;
        default: n = 16;
      endcase
      if (n == 16) v[14:8] = 7'($urandom_range(0, 7));
      half = $urandom_range(2, 5);
      kind = classify(v, n);
      frame(v, n, half, nv, ne, lat, both, bsy);
      apply_model(v, n);
      checks++;
      if (nv !== (kind == 1 ? 1 : 0) || ne !== (kind == 2 ? 1 : 0) || both !== 0) begin
        errors++; $display("FAIL rand_%0d v=%h n=%0d got v%0d e%0d want kind %0d", k, v, n, nv, ne, kind);
      end
      checks++;
      if (wr_addr !== exp_addr || wr_data !== exp_data) begin
        errors++; $display("FAIL rand_data_%0d got %h/%h want %h/%h", k, wr_addr, wr_data, exp_addr, exp_data);
      end
      if (kind == 1) begin
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL rand_lat_%0d got %0d want %0d", k, lat, LAT); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_addr_range();
    test_bad_length();
    test_abort();
    test_ncs_low_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
